// File: rtl/cnn_sequencer.sv
// CNN frame sequencer: walks the image/coefficient memories once per coefficient
// group, captures the compute-unit accumulators after each pass, and hands each
// group result to a consumer with a valid/ready handshake.
module cnn_sequencer #(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned HEIGHT  = 28,
   parameter int unsigned WIDTH   = 28,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned NGROUPS = 4,
   localparam int unsigned NPIX   = HEIGHT * WIDTH,
   localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1,
   localparam int unsigned COEF_W = (NGROUPS * NPIX > 1) ? $clog2(NGROUPS * NPIX) : 1,
   localparam int unsigned GRP_W  = (NGROUPS > 1) ? $clog2(NGROUPS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   output logic                      en,
   output logic                      sof,
   output logic [PIX_W-1:0]          pix_addr,
   output logic [COEF_W-1:0]         coef_addr,
   input  logic [DWIDTH*DEPTH-1:0]   acc_in,
   output logic [DWIDTH*DEPTH-1:0]   out_data,
   output logic [GRP_W-1:0]          out_group,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      done
);

   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGROUPS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSof,
      StRun,
      StDrain,
      StOut,
      StDone
   } state_e;

   state_e                    state_q, state_d;
   logic [PIX_W-1:0]          pix_q, pix_d;
   logic                      drain_q, drain_d;
   logic [GRP_W-1:0]          group_q, group_d;
   logic [DWIDTH*DEPTH-1:0]   out_data_q, out_data_d;
   logic [GRP_W-1:0]          out_group_q, out_group_d;
   logic [COEF_W-1:0]         coef_base;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pix_q       <= '0;
         drain_q     <= 1'b0;
         group_q     <= '0;
         out_data_q  <= '0;
         out_group_q <= '0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         drain_q     <= drain_d;
         group_q     <= group_d;
         out_data_q  <= out_data_d;
         out_group_q <= out_group_d;
      end
   end

   // Next-state logic; abort is applied last so it wins over every other transition.
   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      drain_d     = drain_q;
      group_d     = group_q;
      out_data_d  = out_data_q;
      out_group_d = out_group_q;

      case (state_q)
         StIdle: begin
            if (start && !abort) state_d = StSof;
         end
         StSof: begin
            pix_d   = '0;
            state_d = StRun;
         end
         StRun: begin
            if (pix_q == PIX_LAST) begin
               pix_d   = '0;
               drain_d = 1'b0;
               state_d = StDrain;
            end else begin
               pix_d = pix_q + PIX_W'(1);
            end
         end
         StDrain: begin
            // Two cycles: one for the delayed compute enable, one for the accumulator register.
            if (drain_q) begin
               drain_d     = 1'b0;
               out_data_d  = acc_in;
               out_group_d = group_q;
               state_d     = StOut;
            end else begin
               drain_d = 1'b1;
            end
         end
         StOut: begin
            if (out_ready) begin
               if (group_q == GRP_LAST) begin
                  state_d = StDone;
               end else begin
                  group_d = group_q + GRP_W'(1);
                  state_d = StSof;
               end
            end
         end
         StDone: begin
            group_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         group_d = '0;
         pix_d   = '0;
         drain_d = 1'b0;
      end
   end

   // Decoded outputs; addresses are forced to zero outside RUN.
   always_comb begin
      en        = (state_q == StRun);
      sof       = (state_q == StSof);
      out_valid = (state_q == StOut);
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      coef_base = COEF_W'(group_q) * COEF_W'(NPIX);
      pix_addr  = en ? pix_q : '0;
      coef_addr = en ? (coef_base + COEF_W'(pix_q)) : '0;
      out_data  = out_data_q;
      out_group = out_group_q;
   end

endmodule

// File: tb/tb_cnn_sequencer.sv
// Self-checking bench for cnn_sequencer with a small 2x2 image and two groups.
// A behavioural compute unit accumulates from the addresses the DUT issues; a
// scoreboard holds the expected group results pushed when each frame is started.
module tb_cnn_sequencer;

   localparam int unsigned DW      = 32;
   localparam int unsigned H       = 2;
   localparam int unsigned W       = 2;
   localparam int unsigned DEPTH   = 2;
   localparam int unsigned NGROUPS = 2;
   localparam int unsigned NPIX    = H * W;
   localparam int unsigned PIX_W   = 2;
   localparam int unsigned COEF_W  = 3;
   localparam int unsigned GRP_W   = 1;

   logic                  clk = 1'b0;
   logic                  reset, start, abort, out_ready;
   logic                  en, sof, out_valid, busy, done;
   logic [PIX_W-1:0]      pix_addr;
   logic [COEF_W-1:0]     coef_addr;
   logic [DW*DEPTH-1:0]   acc_in, out_data;
   logic [GRP_W-1:0]      out_group;

   typedef struct packed {
      logic [DW*DEPTH-1:0] data;
      logic [GRP_W-1:0]    grp;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Compute-unit model state
   logic              en_d;
   logic [COEF_W-1:0] coef_d;
   logic [DW-1:0]     acc [DEPTH];

   cnn_sequencer #(
      .DWIDTH  (DW),
      .HEIGHT  (H),
      .WIDTH   (W),
      .DEPTH   (DEPTH),
      .NGROUPS (NGROUPS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .en        (en),
      .sof       (sof),
      .pix_addr  (pix_addr),
      .coef_addr (coef_addr),
      .acc_in    (acc_in),
      .out_data  (out_data),
      .out_group (out_group),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Compute unit: one-cycle enable delay, lane l adds 4 + coef*l per enabled cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_d   <= 1'b0;
         coef_d <= '0;
         for (int l = 0; l < DEPTH; l++) acc[l] <= '0;
      end else begin
         en_d   <= en;
         coef_d <= coef_addr;
         for (int l = 0; l < DEPTH; l++) begin
            if (sof) acc[l] <= '0;
            else if (en_d) acc[l] <= acc[l] + 32'd4 + 32'(coef_d) * 32'(l);
         end
      end
   end

   always_comb begin
      acc_in = '0;
      for (int l = 0; l < DEPTH; l++) acc_in[l*DW +: DW] = acc[l];
   end

   function automatic logic [DW*DEPTH-1:0] exp_data(int g);
      logic [DW*DEPTH-1:0] r;
      logic [DW-1:0]       s;
      r = '0;
      for (int l = 0; l < DEPTH; l++) begin
         s = '0;
         for (int p = 0; p < NPIX; p++) s = s + 32'(4 + (g * NPIX + p) * l);
         r[l*DW +: DW] = s;
      end
      return r;
   endfunction

   task automatic push_frame();
      exp_t e;
      for (int g = 0; g < NGROUPS; g++) begin
         e.data = exp_data(g);
         e.grp  = GRP_W'(g);
         sb.push_back(e);
      end
   endtask

   // Advance one cycle; a handshake visible before the edge is scored against the queue.
   task automatic tick();
      exp_t e;
      if (out_valid === 1'b1 && out_ready && !abort && !reset) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected output group=%0d data=%h", out_group, out_data);
         end else begin
            e = sb.pop_front();
            if ({out_data, out_group} !== {e.data, e.grp}) begin
               errors++;
               $display("FAIL scoreboard: got group=%0d data=%h, expected group=%0d data=%h",
                        out_group, out_data, e.grp, e.data);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_to_done(string name);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s: done not seen within 100 cycles", name);
      end
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d results never delivered, expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({en, sof, out_valid, busy, done, pix_addr, coef_addr, out_group, out_data} !== '0) begin
         errors++;
         $display("FAIL reset: en=%b sof=%b ov=%b busy=%b done=%b pix=%0d coef=%0d grp=%0d, expected all 0",
                  en, sof, out_valid, busy, done, pix_addr, coef_addr, out_group);
      end
      reset = 1'b0;
   endtask

   // Starts on the first edge after reset release; checks the full timeline.
   task automatic test_nominal();
      logic [9:0]        exp_v, got_v;
      logic [PIX_W-1:0]  ep;
      logic [COEF_W-1:0] ec;
      logic              een;
      push_frame();
      start = 1'b1;
      for (int c = 0; c <= 18; c++) begin
         een = 1'b0;
         ep  = '0;
         ec  = '0;
         if (c >= 2 && c <= 5) begin
            een = 1'b1;
            ep  = PIX_W'(c - 2);
            ec  = COEF_W'(c - 2);
         end else if (c >= 10 && c <= 13) begin
            een = 1'b1;
            ep  = PIX_W'(c - 10);
            ec  = COEF_W'(c - 6);
         end
         exp_v = {(c == 1 || c == 9), een, ep, ec, (c == 8 || c == 16), (c == 17),
                  (c >= 1 && c <= 17)};
         got_v = {sof, en, pix_addr, coef_addr, out_valid, done, busy};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL nominal c=%0d: {sof,en,pix,coef,ov,done,busy} got %b expected %b",
                     c, got_v, exp_v);
         end
         if (c == 8) begin
            checks++;
            if (out_data[DW-1:0] !== 32'h10) begin
               errors++;
               $display("FAIL capture: lane0 got %h expected 00000010", out_data[DW-1:0]);
            end
         end
         tick();
         start = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL nominal: %0d results left, expected 0", sb.size());
      end
   endtask

   task automatic test_backpressure();
      push_frame();
      start     = 1'b1;
      out_ready = 1'b0;
      for (int c = 0; c <= 23; c++) begin
         if (c == 13) out_ready = 1'b1;
         if (c >= 8 && c <= 12 && sb.size() > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== sb[0].data || out_group !== sb[0].grp) begin
               errors++;
               $display("FAIL backpressure c=%0d: ov=%b data=%h grp=%0d, expected ov=1 data=%h grp=%0d",
                        c, out_valid, out_data, out_group, sb[0].data, sb[0].grp);
            end
         end
         if (c == 13 || c == 14) begin
            checks++;
            if (sof !== (c == 14)) begin
               errors++;
               $display("FAIL backpressure sof c=%0d: got %b expected %b", c, sof, (c == 14));
            end
         end
         checks++;
         if (done !== (c == 22)) begin
            errors++;
            $display("FAIL backpressure done c=%0d: got %b expected %b", c, done, (c == 22));
         end
         tick();
         start = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL backpressure: %0d results left, expected 0", sb.size());
      end
   endtask

   task automatic test_abort();
      logic seen;
      seen  = 1'b0;
      start = 1'b1;
      for (int c = 0; c <= 25; c++) begin
         abort = (c == 3);
         if (c == 4) begin
            checks++;
            if (en !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL abort c=4: en=%b busy=%b expected 0 0", en, busy);
            end
         end
         if (c >= 4 && (done === 1'b1 || out_valid === 1'b1)) seen = 1'b1;
         tick();
         start = 1'b0;
      end
      abort = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort: done/out_valid seen after abort, expected none");
      end
      push_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (en !== 1'b1 || pix_addr !== '0 || coef_addr !== '0) begin
         errors++;
         $display("FAIL abort restart: en=%b pix=%0d coef=%0d expected 1 0 0", en, pix_addr, coef_addr);
      end
      run_to_done("abort restart");
   endtask

   task automatic test_start_ignored();
      int n_done = 0;
      int at     = -1;
      push_frame();
      for (int c = 0; c <= 25; c++) begin
         start = (c == 0 || c == 2 || c == 7);
         if (done === 1'b1) begin
            n_done++;
            at = c;
         end
         tick();
      end
      start = 1'b0;
      checks++;
      if (n_done != 1 || at != 17) begin
         errors++;
         $display("FAIL start_ignored: done count=%0d last cycle=%0d, expected 1 at 17", n_done, at);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL start_ignored: %0d results left, expected 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         reset = (c == 4);
         if (c == 6) begin
            start = 1'b1;
            push_frame();
         end
         if (c == 5) begin
            checks++;
            if ({en, sof, out_valid, busy, done, pix_addr, coef_addr, out_group, out_data} !== '0) begin
               errors++;
               $display("FAIL reset_mid c=5: en=%b sof=%b ov=%b busy=%b done=%b data=%h, expected all 0",
                        en, sof, out_valid, busy, done, out_data);
            end
         end
         if (c == 7) begin
            checks++;
            if (sof !== 1'b1 || busy !== 1'b1) begin
               errors++;
               $display("FAIL reset_mid c=7: sof=%b busy=%b expected 1 1", sof, busy);
            end
         end
         if (c < 7) tick();
         if (c != 6) start = 1'b0;
      end
      start = 1'b0;
      run_to_done("reset_mid");
   endtask

   task automatic test_abort_priority();
      logic seen;
      seen      = 1'b0;
      out_ready = 1'b1;
      start     = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         abort = (c == 8);
         if (c == 9) begin
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || sof !== 1'b0) begin
               errors++;
               $display("FAIL abort_out c=9: busy=%b ov=%b sof=%b expected 0 0 0", busy, out_valid, sof);
            end
         end
         if (c >= 9 && done === 1'b1) seen = 1'b1;
         tick();
         start = 1'b0;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_out: done seen after abort, expected none");
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || sof !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b sof=%b expected 0 0", busy, sof);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_abort();
      test_start_ignored();
      test_reset_mid();
      test_abort_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cnn_sequencer.md
CNN_SEQUENCER -- requirements
Module: cnn_sequencer

Interface
REQ-001: Parameter DWIDTH, 32, data and accumulator lane width.
REQ-002: Parameter HEIGHT, 28, image rows.
REQ-003: Parameter WIDTH, 28, image columns.
REQ-004: Parameter DEPTH, 8, feature layers computed in parallel per group.
REQ-005: Parameter NGROUPS, 4, coefficient groups per image. Each group is one DEPTH-layer pass. NGROUPS >= 1.
REQ-006: clk  in  1  sole clock; all logic SHALL be rising-edge.
REQ-007: reset  in  1  synchronous, active-high reset.
REQ-008: start  in  1  sampled in IDLE only; begins a frame.
REQ-009: abort  in  1  synchronous cancel of the current frame.
REQ-010: en  out  1  compute enable; memory address is valid this cycle.
REQ-011: sof  out  1  clears the compute accumulators.
REQ-012: pix_addr  out  clog2(HEIGHT*WIDTH)  image memory address.
REQ-013: coef_addr  out  clog2(NGROUPS*HEIGHT*WIDTH)  coefficient memory address.
REQ-014: acc_in  in  DWIDTH*DEPTH  compute-unit accumulator outputs.
REQ-015: out_data  out  DWIDTH*DEPTH  captured group result.
REQ-016: out_group  out  clog2(NGROUPS) (min 1)  group index of out_data.
REQ-017: out_valid  out  1  out_data is valid.
REQ-018: out_ready  in  1  consumer accepts out_data.
REQ-019: busy  out  1  high in any state other than IDLE.
REQ-020: done  out  1  one-cycle pulse at frame completion.

Function
REQ-021: The block SHALL implement the states IDLE, SOF, RUN, DRAIN, OUT and DONE.
REQ-022: IDLE SHALL transition to SOF on start=1; otherwise it SHALL remain in IDLE.
REQ-023: SOF SHALL last one cycle with sof=1 and en=0, then transition to RUN.
REQ-024: RUN SHALL last exactly HEIGHT*WIDTH cycles with en=1.
REQ-025: In RUN, pix_addr SHALL step 0..HEIGHT*WIDTH-1, incrementing by 1 per cycle in raster order.
REQ-026: In RUN, coef_addr SHALL equal group*HEIGHT*WIDTH + pix_addr.
REQ-027: DRAIN SHALL last 2 cycles with en=0, covering the compute enable delay and accumulator register.
REQ-028: At the final DRAIN edge, out_data SHALL load acc_in and out_group SHALL load the group index.
REQ-029: On entering OUT, out_valid SHALL assert; out_valid, out_data and out_group SHALL hold stable until out_ready=1 is sampled.
REQ-030: On an OUT handshake where the group is not the last, the group index SHALL increment and the state SHALL go to SOF.
REQ-031: On an OUT handshake for group NGROUPS-1, the state SHALL go to DONE.
REQ-032: DONE SHALL last one cycle with done=1, then return to IDLE with the group index cleared to 0.
REQ-033: Outside RUN, en SHALL be 0 and pix_addr and coef_addr SHALL be 0.
REQ-034: start SHALL be ignored in every state except IDLE.
REQ-035: abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with out_valid=0, en=0, the group index cleared, and no done pulse.
REQ-036: abort SHALL take priority over start, over an out_ready handshake, and over RUN completion.
REQ-037: When abort and start are both 1 in IDLE, the block SHALL remain in IDLE.
REQ-038: Addresses SHALL never exceed their final values; no wrap-around SHALL occur within a group.
REQ-039: With out_ready held at 1, frame latency from the start-sampled edge to done SHALL be NGROUPS*(HEIGHT*WIDTH+4) cycles.

Reset
REQ-040: reset=1 SHALL force IDLE, with en, sof, out_valid, busy, done, pix_addr, coef_addr, out_group and the group index all 0, and out_data cleared to 0.
REQ-041: reset SHALL override all inputs, including when asserted mid-RUN or mid-OUT.
REQ-042: The first start SHALL be accepted on the first edge after reset deasserts.

Verification (HEIGHT=2, WIDTH=2, NGROUPS=2, cycle 0 = start sampled, out_ready=1)
REQ-043: Nominal frame -> sof in cycle 1; en in cycles 2-5 with pix_addr 0,1,2,3 and coef_addr 0-3; out_valid in cycle 8 with out_group=0; sof in cycle 9; coef_addr 4-7 in cycles 10-13; out_valid in cycle 16 with out_group=1; done in cycle 17.
REQ-044: Capture -> model a compute unit with acc_in lane0 sum=0x10 after cycle 6 -> out_data lane0=0x10 in cycle 8.
REQ-045: Backpressure -> out_ready=0 in cycles 8-12 -> out_valid and out_data stable in cycles 8-12; group 1 sof in cycle 14.
REQ-046: Abort in cycle 3 -> en=0 and busy=0 from cycle 4; no done; a new start restarts at pix_addr 0 with group 0.
REQ-047: start pulsed in cycles 2 and 7 -> ignored; done occurs exactly once, in cycle 17.
REQ-048: reset in cycle 4 -> all outputs 0 in cycle 5; a start in cycle 6 yields sof in cycle 7.
